// File: rtl/joybus_pkg.sv
// Shared joybus constants, state encoding and command bytes.
// Used by the transmitter now and the receiver later.
package joybus_pkg;

  localparam int JB_US_CYCLES        = 40;
  localparam int JB_QUARTERS_PER_BIT = 4;
  localparam int JB_STOP_LOW_US      = 2;

  localparam logic [7:0] JB_CMD_ID     = 8'h00;
  localparam logic [7:0] JB_CMD_POLL   = 8'h40;
  localparam logic [7:0] JB_CMD_ORIGIN = 8'h41;

  typedef enum logic [1:0] {
    JB_IDLE,
    JB_BIT,
    JB_STOP
  } jb_state_e;

endpackage

// File: rtl/joybus_qtick.sv
// Quarter-cell prescaler: counts 0..US_CYCLES-1, pulses qtick_o on terminal.
// Ports: clk_i, rst_i (sync, high), clr_i (sync hold at 0), qtick_o.
module joybus_qtick
  import joybus_pkg::*;
#(
  parameter int US_CYCLES = JB_US_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic qtick_o
);

  localparam int CW = (US_CYCLES > 1) ? $clog2(US_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign qtick_o = (cnt_q == CW'(US_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || qtick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/joybus_tx.sv
// Joybus serializer: valid/ready bytes in, open-drain low-drive out.
// Ports: CLK, RESET, in_data/in_last/in_valid/in_ready, drive_low, busy, underrun.
module joybus_tx
  import joybus_pkg::*;
#(
  parameter int US_CYCLES   = JB_US_CYCLES,
  parameter int STOP_LOW_US = JB_STOP_LOW_US
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       drive_low,
  output logic       busy,
  output logic       underrun
);

  localparam logic [2:0] QLAST = 3'(JB_QUARTERS_PER_BIT - 1);
  localparam logic [2:0] QSTOP = 3'(STOP_LOW_US);

  jb_state_e  state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic [2:0] bit_q, bit_d;
  logic [2:0] quar_q, quar_d;
  logic       dl_q, dl_d;
  logic       busy_q, busy_d;
  logic       qtick;
  logic       take;

  // Prescaler sits at 0 while idle so the first cell is phase-exact.
  joybus_qtick #(
    .US_CYCLES(US_CYCLES)
  ) u_qtick (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .clr_i  (state_q == JB_IDLE),
    .qtick_o(qtick)
  );

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    last_d   = last_q;
    bit_d    = bit_q;
    quar_d   = quar_q;
    busy_d   = busy_q;
    in_ready = 1'b0;
    underrun = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      JB_IDLE: begin
        in_ready = !RESET;
        take     = in_valid && !RESET;
      end
      JB_BIT: begin
        if (qtick) begin
          if (quar_q != QLAST) begin
            quar_d = quar_q + 3'd1;
          end else if (bit_q != 3'd0) begin
            bit_d  = bit_q - 3'd1;
            quar_d = 3'd0;
          end else if (last_q) begin
            state_d = JB_STOP;
            quar_d  = 3'd0;
          end else begin
            // Only window for a follow-on byte: truncate, never stall.
            in_ready = !RESET;
            take     = in_valid && !RESET;
            if (!take) begin
              underrun = !RESET;
              state_d  = JB_STOP;
              quar_d   = 3'd0;
            end
          end
        end
      end
      JB_STOP: begin
        if (qtick) begin
          if (quar_q == QSTOP) begin
            state_d = JB_IDLE;
            quar_d  = 3'd0;
            busy_d  = 1'b0;
          end else begin
            quar_d = quar_q + 3'd1;
          end
        end
      end
      default: state_d = JB_IDLE;
    endcase
    if (take) begin
      state_d = JB_BIT;
      byte_d  = in_data;
      last_d  = in_last;
      bit_d   = 3'd7;
      quar_d  = 3'd0;
      busy_d  = 1'b1;
    end
    // Output is computed from next state so the register edge
    // lands exactly on the quarter boundary.
    dl_d = 1'b0;
    unique case (state_d)
      JB_BIT:  dl_d = (quar_d == 3'd0) ||
                      ((quar_d != QLAST) && !byte_d[bit_d]);
      JB_STOP: dl_d = (quar_d < QSTOP);
      default: dl_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= JB_IDLE;
      byte_q  <= '0;
      last_q  <= 1'b0;
      bit_q   <= '0;
      quar_q  <= '0;
      dl_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      quar_q  <= quar_d;
      dl_q    <= dl_d;
      busy_q  <= busy_d;
    end
  end

  assign drive_low = dl_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_joybus_tx.sv
// Scoreboard bench for joybus_tx at 40 and 4 cycles per quarter.
// Each sample checks {drive_low, busy, in_ready, underrun}.
module tb_joybus_tx;

  localparam int UA = 40;
  localparam int UB = 4;
  localparam int SL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] da, db;
  logic       la, lb, va, vb;
  logic       rda, dla, bsa, una;
  logic       rdb, dlb, bsb, unb;

  joybus_tx #(.US_CYCLES(UA), .STOP_LOW_US(SL)) dut_a (
    .CLK(clk), .RESET(rst),
    .in_data(da), .in_last(la), .in_valid(va),
    .in_ready(rda), .drive_low(dla),
    .busy(bsa), .underrun(una)
  );

  joybus_tx #(.US_CYCLES(UB), .STOP_LOW_US(SL)) dut_b (
    .CLK(clk), .RESET(rst),
    .in_data(db), .in_last(lb), .in_valid(vb),
    .in_ready(rdb), .drive_low(dlb),
    .busy(bsb), .underrun(unb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  task automatic push_byte(input int u, input logic [7:0] d,
                           input logic last, input logic nxt);
    logic dl, rdy;
    for (int b = 7; b >= 0; b--)
      for (int q = 0; q < 4; q++)
        for (int c = 0; c < u; c++) begin
          dl  = (q == 0) || (q < 3 && !d[b]);
          rdy = (b == 0 && q == 3 && c == u - 1 && !last);
          exp_q.push_back({dl, 1'b1, rdy, rdy && !nxt});
        end
  endtask

  task automatic push_stop(input int u);
    for (int c = 0; c < SL * u; c++) exp_q.push_back(4'b1100);
    for (int c = 0; c < u; c++) exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0010);
  endtask

  task automatic run_check(input bit sel, input int n,
                           input string tag);
    logic [3:0] obs, e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      obs = sel ? {dlb, bsb, rdb, unb} : {dla, bsa, rda, una};
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      n_cmp++;
      assert (obs === e) else begin
        n_bad++;
        $error("FAIL %s step %0d: got %b exp %b", tag, i, obs, e);
      end
    end
  endtask

  task automatic run_all(input bit sel, input string tag);
    run_check(sel, exp_q.size(), tag);
  endtask

  initial begin
    rst = 1'b1;
    va = 1'b0; vb = 1'b0;
    da = '0;   db = '0;
    la = 1'b0; lb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(4'b0000); run_check(0, 1, "rst_a");
    exp_q.push_back(4'b0000); run_check(1, 1, "rst_b");
    rst = 1'b0;
    exp_q.push_back(4'b0010); run_check(0, 1, "idle_a");
    exp_q.push_back(4'b0010); run_check(1, 1, "idle_b");

    // single byte 0x80, last
    da = 8'h80; la = 1'b1; va = 1'b1;
    push_byte(UA, 8'h80, 1'b1, 1'b0);
    push_stop(UA);
    run_check(0, 1, "one");
    va = 1'b0;
    run_all(0, "one");

    // 0x00 then 0xFF back to back, second held early
    da = 8'h00; la = 1'b0; va = 1'b1;
    push_byte(UA, 8'h00, 1'b0, 1'b1);
    push_byte(UA, 8'hFF, 1'b1, 1'b0);
    push_stop(UA);
    run_check(0, 1, "two");
    da = 8'hFF; la = 1'b1;
    run_check(0, 32 * UA, "two");
    va = 1'b0;
    run_all(0, "two");

    // underrun after non-last byte
    da = 8'hA5; la = 1'b0; va = 1'b1;
    push_byte(UA, 8'hA5, 1'b0, 1'b0);
    push_stop(UA);
    run_check(0, 1, "under");
    va = 1'b0;
    run_all(0, "under");

    // in_valid/in_data noise while busy
    da = 8'h5A; la = 1'b1; va = 1'b1;
    push_byte(UA, 8'h5A, 1'b1, 1'b0);
    push_stop(UA);
    run_check(0, 1, "noise");
    for (int i = 0; i < 32 * UA + SL * UA; i++) begin
      va = 1'($urandom);
      da = 8'($urandom);
      run_check(0, 1, "noise");
    end
    va = 1'b0;
    run_all(0, "noise");

    // reset mid-byte while drive_low is high
    da = 8'h00; la = 1'b1; va = 1'b1;
    push_byte(UA, 8'h00, 1'b1, 1'b0);
    run_check(0, 1, "mid");
    va = 1'b0;
    run_check(0, 259, "mid");
    exp_q.delete();
    rst = 1'b1; va = 1'b1; da = 8'h3C; la = 1'b1;
    exp_q.push_back(4'b0000);
    run_check(0, 1, "mid_rst");
    rst = 1'b0;
    push_byte(UA, 8'h3C, 1'b1, 1'b0);
    push_stop(UA);
    run_check(0, 1, "restart");
    va = 1'b0;
    run_all(0, "restart");

    // scaled instance: single byte then underrun
    db = 8'h80; lb = 1'b1; vb = 1'b1;
    push_byte(UB, 8'h80, 1'b1, 1'b0);
    push_stop(UB);
    run_check(1, 1, "b_one");
    vb = 1'b0;
    run_all(1, "b_one");
    db = 8'h3C; lb = 1'b0; vb = 1'b1;
    push_byte(UB, 8'h3C, 1'b0, 1'b0);
    push_stop(UB);
    run_check(1, 1, "b_under");
    vb = 1'b0;
    run_all(1, "b_under");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
